// File: rtl/tmds_decoder.sv
// tmds_decoder: per-channel TMDS receive decoder.
// Finds the 10-bit word boundary in a deserialized stream by hunting for
// control tokens, then decodes aligned words into pixel data or c0/c1.
// Optional build macro: TMDS_DECODER_ERRCNT_EN enables the short-token-run
// error counter on err_cnt; without it err_cnt is tied to zero.
module tmds_decoder #(
    parameter int SEARCH_WIN = 1024,
    parameter int TOKEN_RUN  = 8,
    parameter int LOSS_WIN   = 65536,
    parameter int CNT_W      = 17
) (
    input  logic        pixelclk,
    input  logic        rstin,
    input  logic [9:0]  raw_din,
    output logic [7:0]  dout,
    output logic        c0,
    output logic        c1,
    output logic        de,
    output logic        locked,
    output logic [3:0]  slip,
    output logic [15:0] err_cnt
);

    localparam int RC_W = $clog2(TOKEN_RUN + 1);
    localparam logic [CNT_W-1:0] SEARCH_LAST = CNT_W'(SEARCH_WIN - 1);
    localparam logic [CNT_W-1:0] LOSS_LAST   = CNT_W'(LOSS_WIN - 1);
    localparam logic [RC_W-1:0]  RUN_LEN     = RC_W'(TOKEN_RUN);
    localparam logic [RC_W-1:0]  RUN_ONE     = RC_W'(1);

    localparam logic [9:0] TOK_00 = 10'b1101010100;
    localparam logic [9:0] TOK_01 = 10'b0010101011;
    localparam logic [9:0] TOK_10 = 10'b0101010100;
    localparam logic [9:0] TOK_11 = 10'b1010101011;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t           state;
    logic [9:0]       raw_q;
    logic [9:0]       raw_qq;
    logic [9:0]       aligned_r;
    logic [CNT_W-1:0] wcnt;
    logic [RC_W-1:0]  rcnt;
    logic [1:0]       ign_cnt;

    logic [19:0]      window;
    logic [19:0]      window_sh;
    logic             tok_hit;
    logic [1:0]       tok_ctl;
    logic             tok_seen;
    logic [7:0]       q;
    logic [7:0]       d;
    logic [3:0]       slip_adv;

    // Two raw words back to back so any 10-bit window straddling them can be picked
    always_ff @(posedge pixelclk or posedge rstin) begin
        if (rstin) begin
            raw_q  <= '0;
            raw_qq <= '0;
        end else begin
            raw_q  <= raw_din;
            raw_qq <= raw_q;
        end
    end

    // Older word sits in the low half; bit 0 of the stream is the earliest bit
    assign window    = {raw_q, raw_qq};
    assign window_sh = window >> slip;

    // Barrel-shift the two-word window by the current bit offset
    always_ff @(posedge pixelclk or posedge rstin) begin
        if (rstin) aligned_r <= '0;
        else       aligned_r <= window_sh[9:0];
    end

    // Control token recognition on the aligned word
    always_comb begin
        tok_hit = 1'b1;
        tok_ctl = 2'b00;
        case (aligned_r)
            TOK_00:  tok_ctl = 2'b00;
            TOK_01:  tok_ctl = 2'b01;
            TOK_10:  tok_ctl = 2'b10;
            TOK_11:  tok_ctl = 2'b11;
            default: tok_hit = 1'b0;
        endcase
    end

    // Right after a slip change the window still holds stale bits, so tokens
    // are not trusted by the lock logic until the pipeline has refilled
    assign tok_seen = tok_hit && (ign_cnt == 2'd0);

    // Undo the transmit-side inversion and XOR/XNOR transition coding
    always_comb begin
        q = aligned_r[9] ? ~aligned_r[7:0] : aligned_r[7:0];
        d = '0;
        d[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = aligned_r[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
    end

    assign slip_adv = (slip == 4'd9) ? 4'd0 : slip + 4'd1;

    // Word-alignment FSM: hunt offsets, confirm a token run, then watch for loss
    always_ff @(posedge pixelclk or posedge rstin) begin
        if (rstin) begin
            state   <= ST_SEARCH;
            wcnt    <= '0;
            rcnt    <= '0;
            ign_cnt <= '0;
            slip    <= '0;
            locked  <= 1'b0;
        end else begin
            if (ign_cnt != 2'd0) ign_cnt <= ign_cnt - 2'd1;
            case (state)
                ST_SEARCH: begin
                    if (tok_seen) begin
                        rcnt  <= RUN_ONE;
                        state <= ST_VERIFY;
                    end else if (wcnt == SEARCH_LAST) begin
                        slip    <= slip_adv;
                        wcnt    <= '0;
                        ign_cnt <= 2'd2;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                ST_VERIFY: begin
                    if (tok_seen) begin
                        rcnt <= rcnt + RUN_ONE;
                        if (rcnt + RUN_ONE == RUN_LEN) begin
                            state  <= ST_LOCKED;
                            locked <= 1'b1;
                            wcnt   <= '0;
                        end
                    end else begin
                        state <= ST_SEARCH;
                        wcnt  <= '0;
                    end
                end
                ST_LOCKED: begin
                    if (tok_seen) begin
                        wcnt <= '0;
`ifdef TMDS_DECODER_ERRCNT_EN
                        // Track the current token run length, saturating at a full run
                        if (rcnt != RUN_LEN) rcnt <= rcnt + RUN_ONE;
`endif
                    end else begin
`ifdef TMDS_DECODER_ERRCNT_EN
                        rcnt <= '0;
`endif
                        if (wcnt == LOSS_LAST) begin
                            state   <= ST_SEARCH;
                            locked  <= 1'b0;
                            slip    <= slip_adv;
                            wcnt    <= '0;
                            ign_cnt <= 2'd2;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= ST_SEARCH;
                    locked <= 1'b0;
                    wcnt   <= '0;
                end
            endcase
        end
    end

`ifdef TMDS_DECODER_ERRCNT_EN
    // Count token runs that ended short of a full run while locked
    always_ff @(posedge pixelclk or posedge rstin) begin
        if (rstin) begin
            err_cnt <= '0;
        end else if (state == ST_LOCKED && !tok_seen && rcnt != '0 &&
                     rcnt != RUN_LEN && err_cnt != 16'hFFFF) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`else
    assign err_cnt = '0;
`endif

    // Output stage: data or control only once alignment is established
    always_ff @(posedge pixelclk or posedge rstin) begin
        if (rstin) begin
            dout <= '0;
            de   <= 1'b0;
            c0   <= 1'b0;
            c1   <= 1'b0;
        end else if (locked) begin
            if (tok_hit) begin
                dout <= '0;
                de   <= 1'b0;
                c0   <= tok_ctl[0];
                c1   <= tok_ctl[1];
            end else begin
                dout <= d;
                de   <= 1'b1;
            end
        end else begin
            dout <= '0;
            de   <= 1'b0;
            c0   <= 1'b0;
            c1   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tmds_decoder.sv
// tb_tmds_decoder: randomized stream bench for tmds_decoder with an in-bench
// behavioural receiver model compared every cycle, plus literal checkpoints.
`timescale 1ns/100ps
module tb_tmds_decoder;
    localparam int SW = 16;
    localparam int TR = 8;
    localparam int LW = 64;

    logic        pixelclk = 1'b0;
    logic        rstin = 1'b1;
    logic [9:0]  raw_din = '0;
    logic [7:0]  dout;
    logic        c0, c1, de, locked;
    logic [3:0]  slip;
    logic [15:0] err_cnt;

    tmds_decoder #(.SEARCH_WIN(SW), .TOKEN_RUN(TR), .LOSS_WIN(LW), .CNT_W(17)) dut (
        .pixelclk(pixelclk), .rstin(rstin), .raw_din(raw_din),
        .dout(dout), .c0(c0), .c1(c1), .de(de), .locked(locked),
        .slip(slip), .err_cnt(err_cnt)
    );

    always #5 pixelclk = ~pixelclk;

    int total = 0;
    int bad = 0;
    bit bq[$];

`ifdef TMDS_DECODER_ERRCNT_EN
    localparam int ERR_ON = 1;
`else
    localparam int ERR_ON = 0;
`endif

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int tok_code(input logic [9:0] w);
        logic [9:0] toks [4];
        toks = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
        for (int i = 0; i < 4; i++) if (w == toks[i]) return i;
        return -1;
    endfunction

    // d[i] = q[i] xor q[i-1] (xnor when bit 8 clear), d[0] = q[0]
    function automatic logic [7:0] data_of(input logic [9:0] w);
        logic [7:0] qq, x;
        qq = w[9] ? ~w[7:0] : w[7:0];
        x = qq ^ {qq[6:0], 1'b0};
        if (!w[8]) x = x ^ 8'hFE;
        return x;
    endfunction

    function automatic logic [9:0] rand_data();
        logic [9:0] w;
        do w = 10'($urandom); while (tok_code(w) >= 0);
        return w;
    endfunction

    // ---------------- behavioural model ----------------
    logic [9:0]  m_rq, m_rqq, m_al, m_nal;
    logic [19:0] m_win;
    int          m_slip, m_mode, m_w, m_r, m_run, m_ign, m_err, m_tc;
    bit          m_lk, m_hit, m_c0, m_c1, m_de;
    logic [7:0]  m_dout;

    always @(posedge pixelclk or posedge rstin) begin
        if (rstin) begin
            m_rq = '0; m_rqq = '0; m_al = '0;
            m_slip = 0; m_mode = 0; m_w = 0; m_r = 0; m_run = 0; m_ign = 0; m_err = 0;
            m_lk = 0; m_c0 = 0; m_c1 = 0; m_de = 0; m_dout = '0;
        end else begin
            m_tc = tok_code(m_al);
            if (m_lk) begin
                if (m_tc >= 0) begin
                    m_de = 0; m_dout = '0; m_c1 = m_tc[1]; m_c0 = m_tc[0];
                end else begin
                    m_de = 1; m_dout = data_of(m_al);
                end
            end else begin
                m_de = 0; m_dout = '0; m_c0 = 0; m_c1 = 0;
            end
            m_hit = (m_tc >= 0) && (m_ign == 0);
            m_win = {m_rq, m_rqq};
            m_nal = 10'(m_win >> m_slip);
            m_rqq = m_rq;
            m_rq = raw_din;
            if (m_ign > 0) m_ign--;
            if (m_mode == 0) begin
                if (m_hit) begin
                    m_r = 1; m_mode = 1;
                end else if (m_w == SW - 1) begin
                    m_slip = (m_slip + 1) % 10; m_w = 0; m_ign = 2;
                end else m_w++;
            end else if (m_mode == 1) begin
                if (m_hit) begin
                    m_r++;
                    if (m_r == TR) begin m_mode = 2; m_w = 0; m_run = TR; end
                end else begin
                    m_mode = 0; m_w = 0;
                end
            end else begin
                if (m_hit) begin
                    m_w = 0; m_run++;
                end else begin
                    if (ERR_ON != 0 && m_run > 0 && m_run < TR && m_err < 65535) m_err++;
                    m_run = 0;
                    if (m_w == LW - 1) begin
                        m_mode = 0; m_slip = (m_slip + 1) % 10; m_w = 0; m_ign = 2;
                    end else m_w++;
                end
            end
            m_lk = (m_mode == 2);
            m_al = m_nal;
        end
    end

    // Per-cycle compare against the model
    always @(negedge pixelclk) begin
        if (!rstin) begin
            check("cycle", {dout, c1, c0, de, locked, slip, err_cnt},
                  {m_dout, m_c1, m_c0, m_de, m_lk, 4'(m_slip), 16'(m_err)});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tx_word(input logic [9:0] w);
        for (int j = 0; j < 10; j++) bq.push_back(w[j]);
        @(negedge pixelclk);
        for (int j = 0; j < 10; j++) raw_din[j] = bq.pop_front();
        @(posedge pixelclk);
        #1;
    endtask

    task automatic shift_bits(input int n);
        for (int j = 0; j < n; j++) bq.push_back(1'($urandom));
    endtask

    task automatic lock_on(input logic [9:0] tok, input string nm);
        for (int i = 0; i < 400 && !locked; i++) tx_word(tok);
        check(nm, 32'(locked), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit found;
        logic [3:0] s0;
        repeat (3) @(posedge pixelclk);
        #1;
        check("reset", {dout, c1, c0, de, locked, slip, err_cnt}, 32'd0);
        @(negedge pixelclk);
        rstin = 1'b0;

        // aligned stream, offset 0
        repeat (16) tx_word(10'h354);
        tx_word(10'b0111110000);
        repeat (3) tx_word(10'h354);
        check("p1_data", {de, dout}, {23'd0, 1'b1, 8'h10});
        check("p1_lock", {locked, slip}, {27'd0, 1'b1, 4'd0});

        // stream delayed 3 bits
        shift_bits(3);
        found = 0;
        for (int rep = 0; rep < 20 && !found; rep++) begin
            repeat (40) tx_word(10'h2AB);
            if (rep > 0 && locked) begin
                found = 1;
                check("p2_ctl", {slip, c1, c0}, {26'd0, 4'd3, 2'b11});
            end
            repeat (200) tx_word(rand_data());
        end
        check("p2_found", 32'(found), 32'd1);

        // loss of lock after LW non-token words
        lock_on(10'h2AB, "p3_lockwait");
        repeat (10) tx_word(10'h2AB);
        s0 = slip;
        repeat (64) tx_word(rand_data());
        tx_word(rand_data());
        tx_word(rand_data());
        check("p3_hold", 32'(locked), 32'd1);
        tx_word(rand_data());
        check("p3_drop", {locked, slip}, {27'd0, 1'b0, 4'((s0 + 1) % 10)});

        // short run in VERIFY falls back to SEARCH
        @(negedge pixelclk);
        rstin = 1'b1;
        bq.delete();
        @(negedge pixelclk);
        rstin = 1'b0;
        repeat (5) tx_word(10'h354);
        repeat (9) tx_word(rand_data());
        check("p4_verify", {locked, slip}, {27'd0, 1'b0, 4'd0});

        // async reset while locked, then re-lock
        lock_on(10'h354, "p5_lockwait");
        repeat (4) tx_word(10'h354);
        #2 rstin = 1'b1;
        #0.5;
        check("p5_async", {dout, c1, c0, de, locked, slip, err_cnt}, 32'd0);
        #0.5 rstin = 1'b0;
        repeat (12) tx_word(10'h354);
        check("p5_relock", {locked, slip}, {27'd0, 1'b1, 4'd0});

        // short token runs while locked
        tx_word(rand_data());
        repeat (3) begin
            repeat (2) tx_word(10'h354);
            tx_word(rand_data());
        end
        repeat (3) tx_word(rand_data());
        check("p6_err", 32'(err_cnt), (ERR_ON != 0) ? 32'd3 : 32'd0);
        check("p6_lock", 32'(locked), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tmds_decoder.md
# tmds_decoder

Per-channel TMDS receive decoder for the camera/display path: the receive-side counterpart of the DVI transmit encoder. It takes unaligned 10-bit parallel words from a 1:10 deserializer and finds the word boundary by searching for control tokens. It then decodes each aligned word into 8-bit pixel data, or into the c0/c1 control bits with data-enable. It sits between the deserializer and the video timing recovery logic, with one instance per colour channel.

## Interface
Parameters:
- SEARCH_WIN, 1024: cycles spent at one bit offset without a control token before advancing the offset.
- TOKEN_RUN, 8: consecutive control tokens required to declare lock.
- LOSS_WIN, 65536: cycles in LOCKED without any control token before lock is dropped.
- CNT_W, 17: width of the internal window counter; must satisfy 2^CNT_W > max(SEARCH_WIN, LOSS_WIN).

Ports:
- pixelclk  in  1  pixel clock; one raw word per cycle.
- rstin  in  1  asynchronous, active-high reset.
- raw_din  in  10  deserialized word; bit 0 received first.
- dout  out  8  decoded data; 0 when de=0.
- c0  out  1  control bit 0 (hsync on the blue channel).
- c1  out  1  control bit 1 (vsync on the blue channel).
- de  out  1  data enable; 1 = dout valid.
- locked  out  1  word alignment established.
- slip  out  4  current bit offset, 0..9.
- err_cnt  out  16  short-token-run counter (see Configuration).

## Operation
- Stage 1 registers: raw_q <= raw_din; raw_qq <= raw_q.
- Stage 2: aligned_r <= {raw_q, raw_qq}[slip+9 : slip], where raw_qq occupies bits [9:0]. slip=0 gives raw_qq unchanged.
- Token match on aligned_r:
  - 1101010100 -> c1c0=00
  - 0010101011 -> c1c0=01
  - 0101010100 -> c1c0=10
  - 1010101011 -> c1c0=11
- Data decode when aligned_r is not a token:
  - q = aligned_r[9] ? ~aligned_r[7:0] : aligned_r[7:0].
  - d[0] = q[0].
  - d[i] = aligned_r[8] ? q[i]^q[i-1] : ~(q[i]^q[i-1]), for i = 1..7.
- Output stage 3:
  - If locked and token: de=0, dout=0, c1c0 = token value.
  - If locked and data: de=1, dout=d, c0/c1 hold their last token values.
  - If not locked: de=0, dout=0, c0=c1=0.
- Lock FSM, with window counter wcnt and run counter rcnt:
  - SEARCH:
    - A token resets rcnt to 1 and moves to VERIFY.
    - Otherwise wcnt increments. At wcnt = SEARCH_WIN-1: slip <= (slip==9) ? 0 : slip+1, wcnt <= 0, and token matches are ignored for the next 2 cycles (pipeline refill).
  - VERIFY:
    - A token increments rcnt. When rcnt reaches TOKEN_RUN: go to LOCKED, set wcnt <= 0.
    - A non-token returns to SEARCH with slip unchanged and wcnt <= 0.
  - LOCKED:
    - A token sets wcnt <= 0.
    - A non-token increments wcnt. At wcnt = LOSS_WIN-1: go to SEARCH, advance slip, apply the 2-cycle ignore.
- locked = (state == LOCKED), registered.

## Timing
- Reset values: dout=0, c0=0, c1=0, de=0, locked=0, slip=0, err_cnt=0. State=SEARCH; wcnt=rcnt=0; raw_q/raw_qq/aligned_r=0.
- Latency: a word on raw_din at edge k appears on the outputs after edge k+3.
- locked rises the cycle after the TOKEN_RUN-th consecutive token is registered in aligned_r. The first decoded output follows on the next cycle.
- slip wrap-around: 9 -> 0.
- Reset asserted mid-lock: all state and outputs clear immediately, with no waiting for a clock edge.
- A token arriving on the same cycle the SEARCH window expires: the token wins, so the FSM goes to VERIFY and slip is not advanced.
- Tokens during the 2-cycle ignore period are treated as non-tokens.

## Configuration
- TMDS_DECODER_ERRCNT_EN defined:
  - In LOCKED, a token run of length 1..TOKEN_RUN-1 followed by a non-token increments err_cnt.
  - err_cnt is a 16-bit saturating counter (holds at 65535).
  - err_cnt clears only on rstin.
- TMDS_DECODER_ERRCNT_EN undefined: err_cnt is constant 0 and no counting logic is built.

## Test plan
- Aligned stream (serializer offset 0): 16 tokens 1101010100, then data word 0111110000 -> locked=1 with slip=0; on the data word, de=1 and dout=0x10 (checked against the transmit encoder model).
- Stream delayed by 3 bits, SEARCH_WIN=16, repeating 40 × token 1010101011 then 200 data words -> slip reaches the offset that aligns the stream, locked asserts, c1=c0=1 during the tokens.
- After lock, feed LOSS_WIN non-token words (LOSS_WIN=64) -> locked drops on cycle 64 and slip advances by 1.
- In VERIFY, 5 tokens then 1 data word (TOKEN_RUN=8) -> FSM returns to SEARCH, slip unchanged, locked stays 0.
- rstin pulsed for 1 ns while locked -> all outputs 0 asynchronously; re-lock completes normally after release.
- With TMDS_DECODER_ERRCNT_EN, while locked inject 3 runs of 2 tokens each followed by data -> err_cnt=3. Without the macro, the same stimulus gives err_cnt=0.
